// File: rtl/bitlane_shifter.sv
// bitlane_shifter: pops words from a first-word-fall-through source and
// serialises them onto L parallel tx lanes, one beat every div+1 clocks,
// while capturing the same number of rx beats into a low-aligned output word.
// A one-word pending register allows back-to-back words without gaps.
module bitlane_shifter #(
  parameter int       W    = 16,
  parameter int       L    = 1,
  parameter int       DW   = 8,
  parameter logic     IDLE = 1'b1,
  localparam int      B    = W / L,
  localparam int      SW   = $clog2(B + 1)
) (
  input  logic          reset,
  input  logic          clock,
  input  logic [DW-1:0] div,
  input  logic          lsb_first,
  input  logic [W-1:0]  in,
  input  logic [SW-1:0] size,
  output logic          get,
  input  logic          empty,
  output logic [W-1:0]  out,
  output logic          put,
  input  logic [L-1:0]  rx,
  output logic [L-1:0]  tx,
  output logic          busy
);

  localparam logic [SW-1:0] B_S     = SW'(B);
  localparam logic [SW-1:0] ONE_S   = SW'(1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  // Effective beat count: zero or anything beyond B means a full word.
  function automatic logic [SW-1:0] eff_size(input logic [SW-1:0] raw);
    logic [SW-1:0] r;
    if ((raw == {SW{1'b0}}) || (raw > B_S)) begin
      r = B_S;
    end else begin
      r = raw;
    end
    return r;
  endfunction

  // Lane-group index touched by beat k: ascending for LSB-first,
  // descending from the top of the s-beat field for MSB-first.
  function automatic logic [SW-1:0] beat_index(input logic          lsb,
                                               input logic [SW-1:0] s,
                                               input logic [SW-1:0] k);
    logic [SW-1:0] r;
    if (lsb) begin
      r = k;
    end else begin
      r = s - k - ONE_S;
    end
    return r;
  endfunction

  // Extract the L-bit group at a given index of a word.
  function automatic logic [L-1:0] lane_bits(input logic [W-1:0]  w,
                                             input logic [SW-1:0] idx);
    logic [L-1:0] r;
    r = {L{1'b0}};
    for (int b = 0; b < B; b++) begin
      if (idx == SW'(b)) begin
        r = w[b*L +: L];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic          get_q, get_d;
  logic          pend_valid_q, pend_valid_d;
  logic [W-1:0]  pend_word_q, pend_word_d;
  logic [SW-1:0] pend_size_q, pend_size_d;
  logic          active_q, active_d;
  logic [W-1:0]  word_q, word_d;
  logic [SW-1:0] size_q, size_d;
  logic [DW-1:0] div_lat_q, div_lat_d;
  logic          lsb_q, lsb_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] beat_cnt_q, beat_cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  out_q, out_d;
  logic          put_q, put_d;
  logic [L-1:0]  tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          beat_end;
  logic          last_beat;
  logic          load;
  logic [SW-1:0] rx_idx;
  logic [W-1:0]  acc_w;

  // Beat timing, load decision and the accumulator with this clock's rx merged in.
  always_comb begin
    beat_end  = active_q && (div_cnt_q == div_lat_q);
    last_beat = beat_end && (beat_cnt_q == (size_q - ONE_S));
    load      = pend_valid_q && (!active_q || last_beat);
    rx_idx    = beat_index(lsb_q, size_q, beat_cnt_q);
    acc_w     = acc_q;
    if (beat_end) begin
      for (int b = 0; b < B; b++) begin
        if (rx_idx == SW'(b)) begin
          acc_w[b*L +: L] = rx;
        end else begin
          acc_w[b*L +: L] = acc_q[b*L +: L];
        end
      end
    end else begin
      acc_w = acc_q;
    end
  end

  // Source handshake: pop only when the pending slot is free or being drained.
  always_comb begin
    get_d        = !empty && !get_q && (!pend_valid_q || load);
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    pend_size_d  = pend_size_q;
    if (get_q) begin
      pend_valid_d = 1'b1;
      pend_word_d  = in;
      pend_size_d  = size;
    end else if (load) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Shifter sequencing: load, advance beats, finish the word.
  always_comb begin
    active_d   = active_q;
    word_d     = word_q;
    size_d     = size_q;
    div_lat_d  = div_lat_q;
    lsb_d      = lsb_q;
    div_cnt_d  = div_cnt_q;
    beat_cnt_d = beat_cnt_q;
    acc_d      = acc_q;
    if (load) begin
      active_d   = 1'b1;
      word_d     = pend_word_q;
      size_d     = eff_size(pend_size_q);
      div_lat_d  = div;
      lsb_d      = lsb_first;
      div_cnt_d  = {DW{1'b0}};
      beat_cnt_d = {SW{1'b0}};
      acc_d      = {W{1'b0}};
    end else if (last_beat) begin
      active_d   = 1'b0;
      div_cnt_d  = {DW{1'b0}};
      beat_cnt_d = {SW{1'b0}};
      acc_d      = acc_w;
    end else if (beat_end) begin
      div_cnt_d  = {DW{1'b0}};
      beat_cnt_d = beat_cnt_q + ONE_S;
      acc_d      = acc_w;
    end else if (active_q) begin
      div_cnt_d  = div_cnt_q + DIV_ONE;
    end else begin
      active_d   = 1'b0;
    end
  end

  // Registered outputs, derived from the next shifter state so tx changes exactly at beat edges.
  always_comb begin
    put_d  = last_beat;
    busy_d = active_d;
    if (last_beat) begin
      out_d = acc_w;
    end else begin
      out_d = out_q;
    end
    if (active_d) begin
      tx_d = lane_bits(word_d, beat_index(lsb_d, size_d, beat_cnt_d));
    end else begin
      tx_d = {L{IDLE}};
    end
  end

  // State update with synchronous reset discarding both the active and pending word.
  always_ff @(posedge clock) begin
    if (reset) begin
      get_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= {W{1'b0}};
      pend_size_q  <= {SW{1'b0}};
      active_q     <= 1'b0;
      word_q       <= {W{1'b0}};
      size_q       <= {SW{1'b0}};
      div_lat_q    <= {DW{1'b0}};
      lsb_q        <= 1'b0;
      div_cnt_q    <= {DW{1'b0}};
      beat_cnt_q   <= {SW{1'b0}};
      acc_q        <= {W{1'b0}};
      out_q        <= {W{1'b0}};
      put_q        <= 1'b0;
      tx_q         <= {L{IDLE}};
      busy_q       <= 1'b0;
    end else begin
      get_q        <= get_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      pend_size_q  <= pend_size_d;
      active_q     <= active_d;
      word_q       <= word_d;
      size_q       <= size_d;
      div_lat_q    <= div_lat_d;
      lsb_q        <= lsb_d;
      div_cnt_q    <= div_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      put_q        <= put_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign get  = get_q;
  assign put  = put_q;
  assign out  = out_q;
  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bitlane_shifter.sv
// tb_bitlane_shifter: two instances (1 lane and 4 lanes, W=16) driven from a
// queue-based source; every cycle is compared against a timeline model built
// from the word-duration and bit-placement rules.
module tb_bitlane_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  div_drv;
  logic        lsb_drv;
  logic [15:0] in_drv;
  logic [4:0]  size_drv;
  logic [3:0]  rx_drv;
  logic        a_empty, b_empty;
  logic        a_get, b_get, a_put, b_put, a_busy, b_busy;
  logic [15:0] a_out, b_out;
  logic [0:0]  a_tx, a_rx;
  logic [3:0]  b_tx, b_rx;

  int          rxm;
  int          n_vec;
  int          n_bad;
  logic [15:0] exp_out_a, exp_out_b;
  logic [15:0] word_tab [0:7];
  logic [3:0]  rx_hist [0:1023];

  assign a_rx = (rxm == 0) ? a_tx : rx_drv[0:0];
  assign b_rx = (rxm == 0) ? b_tx : rx_drv;

  bitlane_shifter #(.W(16), .L(1), .DW(8), .IDLE(1'b1)) u_a (
    .reset(reset), .clock(clock), .div(div_drv), .lsb_first(lsb_drv),
    .in(in_drv), .size(size_drv), .get(a_get), .empty(a_empty),
    .out(a_out), .put(a_put), .rx(a_rx), .tx(a_tx), .busy(a_busy)
  );

  bitlane_shifter #(.W(16), .L(4), .DW(8), .IDLE(1'b1)) u_b (
    .reset(reset), .clock(clock), .div(div_drv), .lsb_first(lsb_drv),
    .in(in_drv), .size(size_drv[2:0]), .get(b_get), .empty(b_empty),
    .out(b_out), .put(b_put), .rx(b_rx), .tx(b_tx), .busy(b_busy)
  );

  always #5 clock = ~clock;

  // Bit position in the word for beat k, lane j.
  function automatic int bit_pos(input int s, input int lx, input int k, input int j, input bit lsb);
    if (lsb) return k * lx + j;
    return s * lx - lx - k * lx + j;
  endfunction

  function automatic logic [3:0] tx_model(input logic [15:0] w, input int s, input int lx,
                                          input int k, input bit lsb);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < lx; j++) r[j] = w[bit_pos(s, lx, k, j, lsb)];
    return r;
  endfunction

  // Received word: beat k's rx is the value present on the last clock of that beat.
  function automatic logic [15:0] out_model(input int st, input int s, input int lx,
                                            input int per, input bit lsb);
    logic [15:0] r;
    logic [3:0]  v;
    r = 16'h0000;
    for (int k = 0; k < s; k++) begin
      v = rx_hist[st + k * per + per - 1];
      for (int j = 0; j < lx; j++) r[bit_pos(s, lx, k, j, lsb)] = v[j];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_a_tx",   {15'h0000, a_tx}, 16'h0001);
    check("rst_a_busy", {15'h0000, a_busy}, 16'h0000);
    check("rst_a_get",  {15'h0000, a_get}, 16'h0000);
    check("rst_a_put",  {15'h0000, a_put}, 16'h0000);
    check("rst_a_out",  a_out, 16'h0000);
    check("rst_b_tx",   {12'h000, b_tx}, 16'h000F);
    check("rst_b_busy", {15'h0000, b_busy}, 16'h0000);
    check("rst_b_get",  {15'h0000, b_get}, 16'h0000);
    check("rst_b_put",  {15'h0000, b_put}, 16'h0000);
    check("rst_b_out",  b_out, 16'h0000);
  endtask

  // Queue nw words (word_tab) of one geometry into instance sel and check every cycle.
  // abort_t >= 0 asserts reset in that cycle and checks the reset state afterwards.
  task automatic run_stream(input int sel, input int nw, input int sz, input int dv,
                            input bit lsb, input int rxmode, input int abort_t);
    int          lx, bx, s, per, dur, step, tlen, gets, k;
    int          start_c [0:7];
    int          put_c [0:7];
    logic [15:0] q [$];
    bit          pop_flag, prev_get, load_cyc;
    logic [15:0] exp_out, obs_tx, obs_out;
    logic        obs_get, obs_put, obs_busy, exp_busy, exp_put;
    logic [3:0]  exp_tx, lm;
    lx   = (sel == 1) ? 4 : 1;
    bx   = 16 / lx;
    lm   = (sel == 1) ? 4'hF : 4'h1;
    s    = ((sz == 0) || (sz > bx)) ? bx : sz;
    per  = dv + 1;
    dur  = s * per;
    step = (dur >= 2) ? dur : 2;
    for (int i = 0; i < nw; i++) begin
      start_c[i] = 3 + i * step;
      put_c[i]   = start_c[i] + dur;
      q.push_back(word_tab[i]);
    end
    tlen     = put_c[nw-1] + 3;
    gets     = 0;
    pop_flag = 1'b0;
    prev_get = 1'b0;
    exp_out  = (sel == 1) ? exp_out_b : exp_out_a;
    rxm      = rxmode;
    size_drv = 5'(sz);
    for (int t = 0; t < tlen; t++) begin
      @(negedge clock);
      obs_tx   = (sel == 1) ? {12'h000, b_tx} : {15'h0000, a_tx};
      obs_out  = (sel == 1) ? b_out : a_out;
      obs_get  = (sel == 1) ? b_get : a_get;
      obs_put  = (sel == 1) ? b_put : a_put;
      obs_busy = (sel == 1) ? b_busy : a_busy;
      exp_tx   = lm;
      exp_busy = 1'b0;
      exp_put  = 1'b0;
      load_cyc = 1'b0;
      for (int i = 0; i < nw; i++) begin
        if ((t >= start_c[i]) && (t < start_c[i] + dur)) begin
          k        = (t - start_c[i]) / per;
          exp_tx   = tx_model(word_tab[i], s, lx, k, lsb);
          exp_busy = 1'b1;
        end
        if (t == put_c[i]) begin
          exp_put = 1'b1;
          exp_out = out_model(start_c[i], s, lx, per, lsb);
        end
        if (t == start_c[i] - 1) load_cyc = 1'b1;
      end
      check("tx", obs_tx, {12'h000, exp_tx});
      check("busy", {15'h0000, obs_busy}, {15'h0000, exp_busy});
      check("put", {15'h0000, obs_put}, {15'h0000, exp_put});
      check("out", obs_out, exp_out);
      if (t <= 1) check("get_latency", {15'h0000, obs_get}, (t == 1) ? 16'h0001 : 16'h0000);
      if (obs_get) begin
        gets++;
        check("get_gap", {15'h0000, prev_get}, 16'h0000);
      end
      prev_get = obs_get;
      // source: the popped word leaves the head after the capturing edge
      if (pop_flag && (q.size() > 0)) void'(q.pop_front());
      pop_flag = obs_get;
      a_empty  = (sel == 1) ? 1'b1 : (q.size() == 0);
      b_empty  = (sel == 1) ? (q.size() == 0) : 1'b1;
      in_drv   = (q.size() > 0) ? q[0] : 16'($urandom);
      case (rxmode)
        1:       rx_drv = 4'($urandom);
        2:       rx_drv = 4'h0;
        default: rx_drv = 4'($urandom);
      endcase
      rx_hist[t] = ((rxmode == 0) ? exp_tx : rx_drv) & lm;
      if (load_cyc) begin
        div_drv = 8'(dv);
        lsb_drv = lsb;
      end else begin
        div_drv = 8'($urandom);
        lsb_drv = 1'($urandom);
      end
      if (t == abort_t) begin
        reset = 1'b1;
        @(negedge clock);
        check_reset_state();
        reset     = 1'b0;
        a_empty   = 1'b1;
        b_empty   = 1'b1;
        exp_out_a = 16'h0000;
        exp_out_b = 16'h0000;
        return;
      end
    end
    check("get_count", 16'(gets), 16'(nw));
    if (sel == 1) exp_out_b = exp_out;
    else          exp_out_a = exp_out;
    a_empty = 1'b1;
    b_empty = 1'b1;
  endtask

  initial begin
    int sel, bx;
    n_vec    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    a_empty  = 1'b1;
    b_empty  = 1'b1;
    rxm      = 2;
    rx_drv   = 4'h0;
    div_drv  = 8'h00;
    lsb_drv  = 1'b0;
    in_drv   = 16'h0000;
    size_drv = 5'd0;
    repeat (3) @(negedge clock);
    check_reset_state();
    reset     = 1'b0;
    exp_out_a = 16'h0000;
    exp_out_b = 16'h0000;
    @(negedge clock);

    // basic MSB-first loopback, 16 beats
    word_tab[0] = 16'hA5C3;
    run_stream(0, 1, 16, 0, 1'b0, 0, -1);
    // LSB-first, rx held low, 8 beats
    word_tab[0] = 16'h00F1;
    run_stream(0, 1, 8, 0, 1'b1, 2, -1);
    // quad lanes, div=2, 3 beats
    word_tab[0] = 16'h0ABC;
    run_stream(1, 1, 3, 2, 1'b0, 0, -1);

    // streaming: gapless 2-beat words, then 1-clock words with one idle cycle
    for (int i = 0; i < 3; i++) word_tab[i] = 16'($urandom);
    run_stream(0, 3, 2, 0, 1'b0, 1, -1);
    for (int i = 0; i < 3; i++) word_tab[i] = 16'($urandom);
    run_stream(0, 3, 1, 0, 1'b1, 1, -1);
    for (int i = 0; i < 3; i++) word_tab[i] = 16'($urandom);
    run_stream(1, 3, 1, 0, 1'b0, 1, -1);

    // size bounds: 0 and beyond B both mean B beats
    word_tab[0] = 16'($urandom);
    run_stream(0, 1, 0, 0, 1'b0, 0, -1);
    word_tab[0] = 16'($urandom);
    run_stream(0, 1, 19, 1, 1'b1, 0, -1);
    word_tab[0] = 16'($urandom);
    run_stream(1, 1, 0, 1, 1'b0, 0, -1);
    word_tab[0] = 16'($urandom);
    run_stream(1, 1, 7, 0, 1'b1, 0, -1);

    // reset during beat 5 with a second word pending, then a clean restart
    word_tab[0] = 16'h3C5A;
    word_tab[1] = 16'hFFFF;
    run_stream(0, 2, 16, 0, 1'b0, 0, 8);
    word_tab[0] = 16'hA5C3;
    run_stream(0, 1, 16, 0, 1'b0, 0, -1);

    // randomized streams
    for (int r = 0; r < 10; r++) begin
      sel = int'($urandom_range(0, 1));
      bx  = (sel == 1) ? 4 : 16;
      for (int i = 0; i < 3; i++) word_tab[i] = 16'($urandom);
      run_stream(sel, int'($urandom_range(1, 3)), int'($urandom_range(0, bx + 2)),
                 int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bitlane_shifter.md
# bitlane_shifter

Parametrised bit-bang shift engine, successor to the single-lane fixed-width shifter. It pops words from a first-word-fall-through source and serialises them onto `L` parallel tx lanes at a programmable beat rate. It captures the same number of rx bits per word into a parallel output word, with a per-word length, selectable bit order and a one-word prefetch for gapless streaming. It sits between a command/data FIFO and slow serial pins (SPI-like, dual/quad I/O, GPIO bit-bang).

## Interface

- `W`, 16: maximum word width in bits; must be a multiple of `L`.
- `L`, 1: number of parallel lanes, i.e. bits per beat.
- `DW`, 8: width of the beat divider.
- `IDLE`, 1'b1: level driven on every tx lane while no word is shifting.
- Derived `B = W/L` (maximum beats per word) and `SW = $clog2(B+1)`.

Ports (reset is synchronous, active-high; clock is `clock`):

- `reset`  in  1  synchronous, active-high reset.
- `clock`  in  1  clock; all logic on the rising edge.
- `div`  in  DW  beat length minus one; sampled at word load.
- `lsb_first`  in  1  bit order; sampled at word load.
- `in`  in  W  source word, low-aligned; valid while `empty` is low.
- `size`  in  SW  beats for this word; 0 or >B means B.
- `get`  out  1  pop strobe, one cycle; the word is captured at the end of that cycle.
- `empty`  in  1  source has no word.
- `out`  out  W  received word, low-aligned, upper bits zero.
- `put`  out  1  one-cycle strobe; `out` is new in this cycle.
- `rx`  in  L  receive lanes.
- `tx`  out  L  transmit lanes.
- `busy`  out  1  a word is shifting.

## Operation

- Datapath: a pending register holds one word plus its size, and a shifter holds the active word.
- Word geometry: `s` = effective size; `n = s*L` bits in the field `in[n-1:0]`.
- Beat k (0..s-1), lane j:
  - MSB-first: tx = `in[n-L-k*L+j]`; rx lands in `out[n-L-k*L+j]`.
  - LSB-first: tx = `in[k*L+j]`; rx lands in `out[k*L+j]`.
- Beat length is `div+1` clocks. Each beat's tx is stable for the whole beat. rx is sampled on the last clock of the beat.
- `get` rule: next `get` = `!empty & !get & (!pending_valid | load)`. Here `load` means the shifter takes the pending word at this edge. `get` is never high two cycles in a row.
- Load: the shifter loads pending when it is idle, or on the edge that completes its last beat.
  - At load it latches `div`, `lsb_first` and `s`, and clears its rx accumulator.
  - `busy` is high from the first beat through the last beat.
- Completion: `put` is high for one cycle after the last sample. `out` updates in that cycle and holds until the next `put`. There is no backpressure; the consumer must accept every `put`.
- Idle: tx = `{L{IDLE}}` whenever no beat is active, including one-cycle gaps between words.
- `div`/`lsb_first` changes mid-word have no effect until the next load.
- Reset at any time:
  - The current and pending words are discarded.
  - No `put` is issued for the aborted word.
  - Reset values: `get`=0, `put`=0, `busy`=0, `out`=0, tx=`{L{IDLE}}`, divider and beat counters 0.

## Timing

- If `get` is high in cycle c and the shifter is idle:
  - load happens at the end of c+1;
  - beat 0 drives tx in cycles c+2 .. c+2+div;
  - `put` is high in cycle c+2+s*(div+1).
- Word duration is `s*(div+1)` clocks.
- Streaming:
  - Consecutive words are gapless when the duration is ≥ 2 clocks.
  - Words lasting 1 clock (s=1, div=0) are separated by exactly one idle cycle.
- `put` for word A and beat 0 of word B may share a cycle.
- `empty` rising while pending is valid has no effect on queued words.

## Test plan

- **Basic loopback:** W=16, L=1, div=0, MSB-first, size=16, `in`=16'hA5C3, rx=tx.
  - tx carries 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, one bit per clock.
  - `put` comes 18 cycles after `get` with `out`=16'hA5C3.
- **LSB-first, rx=0:** size=8, `in`=16'h00F1.
  - tx carries 1,0,0,0,1,1,1,1, then returns to idle 1.
  - `out`=16'h0000.
- **Quad lanes:** L=4, div=2, size=3, `in`=16'h0ABC, MSB-first, rx=tx.
  - tx carries 4'hA, 4'hB, 4'hC for 3 clocks each.
  - `put` comes 11 cycles after `get` with `out`=16'h0ABC.
- **Streaming:** three queued words.
  - size=2, div=0: no idle cycle on tx; `put` pulses spaced 2 cycles apart.
  - size=1, div=0: one idle cycle between words; `put` pulses spaced 2 cycles apart.
- **Reset mid-word:** assert `reset` during beat 5 with a word pending.
  - Next cycle: tx=`{L{IDLE}}`, `busy`=0, `get`=0, `out`=0; no `put`.
  - After reset releases, the next source word starts cleanly with the same latency as the basic case.
- **Size bounds:** size=0 and size=B+3.
  - Both shift B beats.
  - `out` equals the full W-bit loopback word.
